// File: rtl/hdr_arbiter_if.sv
// hdr_arbiter_if: pixel/header types and the arbiter handshake bundle.
// slave is the arbiter side, master is the requester/consumer environment.
package types;
   typedef struct packed {
      logic [7:0] r, g, b, a;
   } pixel_t;
   typedef pixel_t [31:0] pixels_t;
   typedef struct packed {
      logic [7:0] r_min, g_min, b_min, a_min;
      logic       compressable;
   } header_t;
   typedef struct packed {
      header_t    header;
      logic [7:0] max_delta;
   } header_residual_reg;
endpackage

interface hdr_arbiter_if #(parameter int NREQ = 4);
   localparam int SW = $clog2(NREQ);
   logic [NREQ-1:0] req_valid, req_ready;
   types::pixels_t [NREQ-1:0] req_pixels;
   types::pixels_t hdr_pixels;
   types::header_residual_reg hdr_result, out_result;
   logic out_valid, out_ready, flush_req, flush_ack;
   logic [SW-1:0] out_src;
   modport slave (
      input  req_valid, req_pixels, hdr_result, out_ready, flush_req,
      output req_ready, hdr_pixels, out_valid, out_result, out_src, flush_ack
   );
   modport master (
      output req_valid, req_pixels, hdr_result, out_ready, flush_req,
      input  req_ready, hdr_pixels, out_valid, out_result, out_src, flush_ack
   );
endinterface

// File: rtl/hdr_arbiter.sv
// hdr_arbiter: round-robin tile arbiter feeding one header unit, with credit-limited result FIFO.
// Optional HDR_ARBITER_PERF_CNT_EN adds per-requester saturating grant counters.
module hdr_arbiter #(
   parameter int NREQ       = 4,
   parameter int FIFO_DEPTH = 2
) (
   input logic clk,
   input logic rst,
   hdr_arbiter_if.slave bus
`ifdef HDR_ARBITER_PERF_CNT_EN
   ,
   output logic [NREQ-1:0][31:0] grant_cnt
`endif
);
   localparam int SW = $clog2(NREQ);
   localparam int AW = $clog2(FIFO_DEPTH);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
   state_t state;
   logic [SW-1:0] ptr, gnt_idx, inf_src;
   logic inf_v, gnt, pop, push, credit, pipe_empty;
   logic [NREQ-1:0] grant_vec;
   logic [AW:0] count;
   logic [AW-1:0] head, tail;
   types::header_residual_reg mem_res [FIFO_DEPTH];
   logic [SW-1:0] mem_src [FIFO_DEPTH];

   // search from the slot after the last grant; the lowest offset wins
   always_comb begin
      gnt = 1'b0;
      gnt_idx = '0;
      for (int k = NREQ; k >= 1; k--)
         if (bus.req_valid[(int'(ptr) + k) % NREQ]) begin
            gnt = 1'b1;
            gnt_idx = SW'((int'(ptr) + k) % NREQ);
         end
   end

   assign pop = bus.out_valid && bus.out_ready;
   assign push = inf_v;
   assign pipe_empty = !inf_v && count == '0;
   assign credit = (int'(count) - int'(pop) + int'(inf_v)) < FIFO_DEPTH;
   assign grant_vec = (gnt && credit && state != DRAIN && !rst) ? NREQ'(1) << gnt_idx : '0;
   assign bus.req_ready = grant_vec;
   assign bus.hdr_pixels = |grant_vec ? bus.req_pixels[gnt_idx] : '0;
   assign bus.out_valid = count != '0 && !rst;
   assign bus.out_result = bus.out_valid ? mem_res[head] : '0;
   assign bus.out_src = bus.out_valid ? mem_src[head] : '0;
   assign bus.flush_ack = state == DRAIN && pipe_empty && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         ptr <= SW'(NREQ - 1);
         inf_v <= 1'b0;
         inf_src <= '0;
         count <= '0;
         head <= '0;
         tail <= '0;
      end else begin
         inf_v <= |grant_vec;
         inf_src <= gnt_idx;
         if (|grant_vec) ptr <= gnt_idx;
         if (push) tail <= tail + 1'b1;
         if (pop) head <= head + 1'b1;
         count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
         state <= state == DRAIN ? (pipe_empty ? IDLE : DRAIN) :
                  bus.flush_req ? DRAIN :
                  |bus.req_valid ? RUN :
                  pipe_empty ? IDLE : state;
      end
   end

   always_ff @(posedge clk)
      if (push) begin
         mem_res[tail] <= bus.hdr_result;
         mem_src[tail] <= inf_src;
      end

`ifdef HDR_ARBITER_PERF_CNT_EN
   always_ff @(posedge clk)
      for (int i = 0; i < NREQ; i++)
         if (rst) grant_cnt[i] <= '0;
         else if (grant_vec[i] && grant_cnt[i] != '1) grant_cnt[i] <= grant_cnt[i] + 32'd1;
`endif
endmodule

// File: tb/tb_hdr_arbiter.sv
// tb_hdr_arbiter: directed and random stimulus against a queue-based reference model.
// Drives a behavioural header unit that answers one cycle after each tile.
module tb_hdr_arbiter;
   localparam int NREQ = 4;
   localparam int DEPTH = 2;
   localparam int SW = 2;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   hdr_arbiter_if #(.NREQ(NREQ)) bus ();
`ifdef HDR_ARBITER_PERF_CNT_EN
   logic [NREQ-1:0][31:0] grant_cnt;
   hdr_arbiter #(.NREQ(NREQ), .FIFO_DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus), .grant_cnt(grant_cnt));
`else
   hdr_arbiter #(.NREQ(NREQ), .FIFO_DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

   typedef struct {
      types::header_residual_reg res;
      int src;
   } ent_t;
   ent_t q[$];
   bit inf = 0;
   int inf_src = 0;
   types::pixels_t inf_px;
   int last = NREQ - 1;
   bit draining = 0;
   int checks = 0, failures = 0, cyc = 0;
   int n_gnt, n_ov, n_ack, first_ov;
   int gseq[$], sseq[$];
   logic o_valid, o_ack;
   logic [NREQ-1:0] o_ready;
   logic [SW-1:0] o_src;
   types::header_residual_reg o_res;

   function automatic types::header_residual_reg hf(types::pixels_t p);
      types::header_residual_reg h;
      logic [7:0] mn [4], mx [4], v, md;
      logic [31:0] w;
      for (int c = 0; c < 4; c++) begin
         mn[c] = 8'hff;
         mx[c] = 8'h00;
      end
      for (int i = 0; i < 32; i++) begin
         w = p[i];
         for (int c = 0; c < 4; c++) begin
            v = w[31 - 8 * c -: 8];
            if (v < mn[c]) mn[c] = v;
            if (v > mx[c]) mx[c] = v;
         end
      end
      md = 8'h00;
      for (int c = 0; c < 4; c++) if (mx[c] - mn[c] > md) md = mx[c] - mn[c];
      h.header.r_min = mn[0];
      h.header.g_min = mn[1];
      h.header.b_min = mn[2];
      h.header.a_min = mn[3];
      h.header.compressable = md < 8'h80;
      h.max_delta = md;
      return h;
   endfunction

   function automatic types::pixels_t rpx();
      logic [1023:0] v;
      for (int i = 0; i < 32; i++) v[32 * i +: 32] = $urandom;
      return v;
   endfunction

   task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic randomize_pixels();
      for (int i = 0; i < NREQ; i++) bus.req_pixels[i] = rpx();
   endtask

   task automatic tick();
      bit pop, g, ack, gd;
      int gi;
      logic [NREQ-1:0] ev;
      types::pixels_t ep, cap;
      types::header_residual_reg eres;
      logic [SW-1:0] esrc;
      logic [1023:0] a, b;
      logic [63:0] rnd;
      @(negedge clk);
      pop = !rst && q.size() > 0 && bus.out_ready;
      g = 0;
      gi = 0;
      if (!rst && !draining && q.size() - int'(pop) + int'(inf) < DEPTH)
         for (int k = 1; k <= NREQ && !g; k++)
            if (bus.req_valid[(last + k) % NREQ]) begin
               g = 1;
               gi = (last + k) % NREQ;
            end
      ev = '0;
      if (g) ev[gi] = 1'b1;
      ep = g ? bus.req_pixels[gi] : '0;
      eres = (!rst && q.size() > 0) ? q[0].res : '0;
      esrc = (!rst && q.size() > 0) ? SW'(q[0].src) : '0;
      ack = !rst && draining && !inf && q.size() == 0;
      chk("req_ready", 256'(bus.req_ready), 256'(ev));
      chk("out_valid", 256'(bus.out_valid), 256'(!rst && q.size() > 0));
      chk("out_result", 256'(bus.out_result), 256'(eres));
      chk("out_src", 256'(bus.out_src), 256'(esrc));
      chk("flush_ack", 256'(bus.flush_ack), 256'(ack));
      a = bus.hdr_pixels;
      b = ep;
      for (int j = 0; j < 4; j++) chk("hdr_pixels", a[256 * j +: 256], b[256 * j +: 256]);
      o_valid = bus.out_valid;
      o_ack = bus.flush_ack;
      o_ready = bus.req_ready;
      o_src = bus.out_src;
      o_res = bus.out_result;
      cap = bus.hdr_pixels;
      gd = |bus.req_ready;
      if (gd) begin
         n_gnt++;
         for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) gseq.push_back(i);
      end
      if (bus.out_valid) begin
         n_ov++;
         sseq.push_back(int'(bus.out_src));
         if (first_ov < 0) first_ov = cyc;
      end
      if (bus.flush_ack) n_ack++;
      @(posedge clk);
      #1;
      cyc++;
      if (rst) begin
         q.delete();
         inf = 0;
         last = NREQ - 1;
         draining = 0;
      end else begin
         if (pop) void'(q.pop_front());
         if (inf) q.push_back('{hf(inf_px), inf_src});
         if (draining && ack) draining = 0;
         else if (!draining && bus.flush_req) draining = 1;
         inf = g;
         inf_px = ep;
         inf_src = gi;
         if (g) last = gi;
      end
      rnd = {$urandom, $urandom};
      bus.hdr_result = gd ? hf(cap) : rnd[$bits(types::header_residual_reg)-1:0];
   endtask

   task automatic clear_stats();
      n_gnt = 0;
      n_ov = 0;
      n_ack = 0;
      first_ov = -1;
      cyc = 0;
      gseq.delete();
      sseq.delete();
   endtask

   task automatic idle_ticks(int n);
      bus.req_valid = '0;
      bus.out_ready = 1'b1;
      bus.flush_req = 1'b0;
      repeat (n) tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      types::pixels_t t;
      int exp_seq [5];
      exp_seq = '{0, 1, 2, 3, 0};
      rst = 1'b1;
      bus.req_valid = '1;
      bus.out_ready = 1'b1;
      bus.flush_req = 1'b0;
      bus.hdr_result = '0;
      randomize_pixels();
      clear_stats();
      tick();
      tick();
      rst = 1'b0;

      clear_stats();
      repeat (8) begin
         randomize_pixels();
         tick();
      end
      for (int i = 0; i < 5; i++) begin
         chk("rr_grant_order", 256'(gseq[i]), 256'(exp_seq[i]));
         chk("rr_src_order", 256'(sseq[i]), 256'(exp_seq[i]));
      end
      chk("first_result_cycle", 256'(first_ov), 256'(2));

      do_reset();
      clear_stats();
      bus.req_valid = 4'b0100;
      bus.out_ready = 1'b0;
      repeat (6) tick();
      chk("credit_stall_grants", 256'(n_gnt), 256'(2));
      chk("credit_stall_ready", 256'(o_ready), 256'(0));
      n_gnt = 0;
      bus.out_ready = 1'b1;
      repeat (6) tick();
      chk("credit_resume_grants", 256'(n_gnt), 256'(6));

      idle_ticks(4);
      for (int i = 0; i < 32; i++) t[i] = '{8'h40, 8'h40, 8'h40, 8'h40};
      t[5].r = 8'h03;
      bus.req_pixels[0] = t;
      bus.req_valid = 4'b0001;
      tick();
      bus.req_valid = '0;
      tick();
      tick();
      chk("hdr_valid", 256'(o_valid), 256'(1));
      chk("hdr_r_min", 256'(o_res.header.r_min), 256'(8'h03));
      chk("hdr_g_min", 256'(o_res.header.g_min), 256'(8'h40));
      chk("hdr_b_min", 256'(o_res.header.b_min), 256'(8'h40));
      chk("hdr_a_min", 256'(o_res.header.a_min), 256'(8'h40));
      chk("hdr_compressable", 256'(o_res.header.compressable), 256'(1));
      chk("hdr_src", 256'(o_src), 256'(0));

      idle_ticks(4);
      bus.req_valid = 4'b0100;
      bus.out_ready = 1'b0;
      tick();
      tick();
      clear_stats();
      bus.req_valid = '0;
      bus.out_ready = 1'b1;
      bus.flush_req = 1'b1;
      tick();
      bus.flush_req = 1'b0;
      bus.req_valid = '1;
      tick();
      tick();
      chk("drain_no_grants", 256'(n_gnt), 256'(0));
      chk("drain_results", 256'(n_ov), 256'(2));
      chk("drain_ack_count", 256'(n_ack), 256'(1));
      chk("drain_ack_last", 256'(o_ack), 256'(1));
      tick();
      chk("post_drain_ack", 256'(o_ack), 256'(0));
      chk("post_drain_grant", 256'(|o_ready), 256'(1));
      idle_ticks(4);
      bus.flush_req = 1'b1;
      tick();
      chk("empty_flush_no_ack_yet", 256'(o_ack), 256'(0));
      bus.flush_req = 1'b0;
      tick();
      chk("empty_flush_ack", 256'(o_ack), 256'(1));

      idle_ticks(2);
      bus.req_valid = '1;
      bus.out_ready = 1'b0;
      repeat (4) tick();
      chk("fifo_full_valid", 256'(o_valid), 256'(1));
      rst = 1'b1;
      tick();
      chk("rst_out_valid", 256'(o_valid), 256'(0));
      rst = 1'b0;
      bus.req_valid = '0;
      bus.out_ready = 1'b1;
      clear_stats();
      repeat (4) tick();
      chk("no_stale_after_rst", 256'(n_ov), 256'(0));

      do_reset();
      clear_stats();
      bus.req_valid = 4'b0010;
      repeat (10) tick();
      bus.req_valid = '0;
      chk("req1_grants", 256'(n_gnt), 256'(10));
`ifdef HDR_ARBITER_PERF_CNT_EN
      for (int i = 0; i < NREQ; i++) chk("grant_cnt", 256'(grant_cnt[i]), 256'(i == 1 ? 10 : 0));
`endif

      for (int n = 0; n < 500; n++) begin
         randomize_pixels();
         bus.req_valid = NREQ'($urandom);
         bus.out_ready = $urandom_range(0, 3) != 0;
         bus.flush_req = $urandom_range(0, 29) == 0;
         rst = $urandom_range(0, 99) == 0;
         tick();
      end
      rst = 1'b0;
      idle_ticks(4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/hdr_arbiter.md
HDR_ARBITER -- requirements
Module: hdr_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of tile requesters sharing one header/residual unit (2..8).
REQ-002 Parameter FIFO_DEPTH, default 2, output buffer entries (power of two, >=2).
REQ-003 clk  input  1  clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  NREQ  per-requester tile valid.
REQ-006 req_pixels  input  NREQ x types::pixels_t  per-requester 32-pixel RGBA tile.
REQ-007 req_ready  output  NREQ  one-hot grant; a tile transfers when req_valid[i] and req_ready[i] are both high.
REQ-008 hdr_pixels  output  types::pixels_t  tile driven to the header unit.
REQ-009 hdr_result  input  types::header_residual_reg  header unit result, valid exactly 1 cycle after hdr_pixels.
REQ-010 out_valid / out_ready  output / input  1 / 1  result handshake toward the residual/packer stage.
REQ-011 out_result  output  types::header_residual_reg  buffered result.
REQ-012 out_src  output  $clog2(NREQ)  requester index of out_result.
REQ-013 flush_req / flush_ack  input / output  1 / 1  drain request and single-cycle completion pulse.

Function
REQ-014 Grant is round-robin; the requester after the last granted index has highest priority; no requester is granted twice while another valid requester waits.
REQ-015 At most one grant per cycle; req_ready is purely combinational from req_valid, pointer, credit and state.
REQ-016 hdr_pixels equals req_pixels of the granted requester in the grant cycle, else all zeros.
REQ-017 A one-stage in-flight tracker (valid bit + source index) marks the cycle in which hdr_result corresponds to an issued tile; only then is hdr_result written into the FIFO.
REQ-018 Credit rule: grant permitted only if fifo_count + inflight < FIFO_DEPTH, where a same-cycle FIFO pop does not count toward the limit.
REQ-019 FIFO stores {hdr_result, src}; out_valid = FIFO non-empty; pop on out_valid && out_ready; simultaneous push and pop leave the count unchanged; head/tail pointers wrap modulo FIFO_DEPTH.
REQ-020 End-to-end latency, empty FIFO, out_ready high: grant cycle N -> out_valid in cycle N+2.
REQ-021 FSM states IDLE, RUN, DRAIN; IDLE->RUN on any req_valid; RUN->IDLE when no req_valid, no inflight and FIFO empty; IDLE/RUN->DRAIN on flush_req.
REQ-022 In DRAIN, req_ready is all zeros; DRAIN->IDLE when inflight clear and FIFO empty, with flush_ack high for exactly that cycle.
REQ-023 flush_req asserted while already in DRAIN is ignored; flush_req in a cycle with an empty pipe produces flush_ack in the next cycle.
REQ-024 out_result and out_src remain stable while out_valid is high and out_ready is low.

Reset
REQ-025 On rst: state IDLE, round-robin pointer so requester 0 has highest priority, inflight 0, FIFO empty.
REQ-026 During and after rst, until the next clk edge: req_ready 0, out_valid 0, flush_ack 0, out_src 0, out_result 0.
REQ-027 rst asserted mid-operation discards the in-flight tile and FIFO contents without producing output.

Configuration
REQ-028 Macro HDR_ARBITER_PERF_CNT_EN, when defined, adds output grant_cnt (NREQ x 32): per-requester saturating counters incremented on each transfer, cleared by rst.
REQ-029 Without HDR_ARBITER_PERF_CNT_EN, the port and counters do not exist; all other behaviour is identical.

Verification
REQ-030 rst, then req_valid=4'b1111 held, out_ready=1 -> grants in order 0,1,2,3,0; one result per cycle from cycle 2; out_src follows the same sequence.
REQ-031 Single requester 2 valid, out_ready=0 -> exactly 2 grants, then req_ready=0; raising out_ready restores one grant per cycle.
REQ-032 Tile with all channels = 8'h40 except pixel 5 R = 8'h03 -> out_result.header r_min=03, g/b/a_min=40, compressable=1, two cycles after grant.
REQ-033 flush_req pulsed while 1 inflight and 1 FIFO entry, out_ready=1 -> no further grants, 2 results drained, flush_ack single pulse, then IDLE.
REQ-034 rst asserted with FIFO full -> out_valid=0 the next cycle; no stale result appears after rst is released.
REQ-035 With HDR_ARBITER_PERF_CNT_EN defined, 10 grants to requester 1 -> grant_cnt[1]=10; all other grant_cnt entries = 0.
